// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder: pulls one tile of activations out of the per-row input
// FIFOs and feeds the left edge of the MAC array with a diagonal skew
// (row i lags row 0 by i cycles). All rows stall together so the skew holds.

// Per-row slice: activity window, read enable and the two-stage read pipeline.
module systolic_row_lane #(
  parameter int data_size = 8,
  parameter int tile_len  = 16,
  parameter int row_idx   = 0,
  parameter int tw        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [tw-1:0]        t,
  input  logic                 issue,
  input  logic [data_size-1:0] fifo_data,
  output logic                 active,
  output logic                 r_en,
  output logic [data_size-1:0] a_out,
  output logic                 a_valid
);

  localparam logic [tw:0] HI = (tw+1)'(row_idx + tile_len);

  logic lo_ok;
  logic rd_d1;

  // Row 0 is active from step 0, so its lower bound is trivially met.
  generate
    if (row_idx == 0) begin : g_lo0
      assign lo_ok = 1'b1;
    end else begin : g_lo
      localparam logic [tw:0] LO = (tw+1)'(row_idx);
      assign lo_ok = ({1'b0, t} >= LO);
    end
  endgenerate

  assign active = lo_ok && ({1'b0, t} < HI);
  assign r_en   = issue && active;

  // FIFO data lands one cycle after r_en; capture it then, else drive a zero bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d1   <= 1'b0;
      a_out   <= '0;
      a_valid <= 1'b0;
    end else begin
      rd_d1 <= r_en;
      if (rd_d1) begin
        a_out   <= fifo_data;
        a_valid <= 1'b1;
      end else begin
        a_out   <= '0;
        a_valid <= 1'b0;
      end
    end
  end

endmodule

module systolic_row_feeder #(
  parameter int data_size = 8,
  parameter int num_rows  = 4,
  parameter int tile_len  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [num_rows-1:0]           fifo_empty,
  input  logic [num_rows*data_size-1:0] fifo_data,
  output logic [num_rows-1:0]           fifo_r_en,
  output logic [num_rows*data_size-1:0] a_out,
  output logic [num_rows-1:0]           a_valid,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   stall_cnt
);

  localparam int            TW     = $clog2(tile_len + num_rows);
  localparam logic [TW-1:0] T_LAST = TW'(tile_len + num_rows - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     t;
  logic              drain_cnt;
  logic [num_rows-1:0] active;
  logic              stall;
  logic              issue;

  // Only rows inside their window can stall the tile; an empty idle row is harmless.
  assign stall = (state == RUN) && (|(active & fifo_empty));
  assign issue = (state == RUN) && !stall;

  generate
    for (genvar i = 0; i < num_rows; i++) begin : g_row
      systolic_row_lane #(
        .data_size (data_size),
        .tile_len  (tile_len),
        .row_idx   (i),
        .tw        (TW)
      ) u_lane (
        .clk       (clk),
        .reset     (reset),
        .t         (t),
        .issue     (issue),
        .fifo_data (fifo_data[i*data_size +: data_size]),
        .active    (active[i]),
        .r_en      (fifo_r_en[i]),
        .a_out     (a_out[i*data_size +: data_size]),
        .a_valid   (a_valid[i])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs; DRAIN covers FIFO latency plus the output register.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && (t == T_LAST)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Step counter, drain timer and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      t         <= '0;
      drain_cnt <= 1'b0;
      stall_cnt <= '0;
    end else begin
      drain_cnt <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            t         <= '0;
            stall_cnt <= '0;
          end
        end
        RUN: begin
          if (stall) begin
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
          end else begin
            t <= t + TW'(1);
          end
        end
        DRAIN:   drain_cnt <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Bench for systolic_row_feeder: a queue-based FIFO model per row feeds the DUT,
// every element read is pushed to a per-row scoreboard and popped when it
// reaches a_out. Cycle-level tables cover skew, stalls, reset and restarts.
module tb_systolic_row_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, start_b;
  logic [3:0]       fifo_empty, fifo_r_en, a_valid, emask, qe;
  logic [3:0][7:0]  fdout, aout;
  logic             busy, done;
  logic [15:0]      stall_cnt;

  logic             fe_b, ren_b, av_b, busy_b, done_b, qe_b;
  logic [7:0]       fd_b, ao_b;
  logic [15:0]      sc_b;

  logic [7:0] fq[4][$];
  logic [7:0] expq[4][$];
  logic [7:0] fq_b[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] ren_tab[16];
  logic [3:0] mask_tab[16];

  assign fifo_empty = qe | emask;
  assign fe_b       = qe_b;

  systolic_row_feeder #(.data_size(8), .num_rows(4), .tile_len(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_data  (fdout),
    .fifo_r_en  (fifo_r_en),
    .a_out      (aout),
    .a_valid    (a_valid),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt)
  );

  systolic_row_feeder #(.data_size(8), .num_rows(1), .tile_len(1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .fifo_empty (fe_b),
    .fifo_data  (fd_b),
    .fifo_r_en  (ren_b),
    .a_out      (ao_b),
    .a_valid    (av_b),
    .busy       (busy_b),
    .done       (done_b),
    .stall_cnt  (sc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // FIFO models: one-cycle read latency, empty reflects the previous cycle's reads.
  always @(posedge clk) begin
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      if (fifo_r_en[i] === 1'b1) begin
        chk("fifo_nonempty_on_read", 32'(fq[i].size() > 0), 1);
        if (fq[i].size() > 0) begin
          v = fq[i].pop_front();
          fdout[i] <= v;
          expq[i].push_back(v);
        end
      end
      qe[i] <= (fq[i].size() == 0);
    end
    if (ren_b === 1'b1 && fq_b.size() > 0) fd_b <= fq_b.pop_front();
    qe_b <= (fq_b.size() == 0);
  end

  // Scoreboard: each valid lane must carry the next element read from that row.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (a_valid[i] === 1'b1) begin
        chk("sb_have_expected", 32'(expq[i].size() > 0), 1);
        if (expq[i].size() > 0) chk("sb_data", aout[i], expq[i].pop_front());
      end else begin
        chk("sb_bubble_zero", aout[i], 0);
      end
    end
  end

  task automatic load(input int n);
    for (int i = 0; i < 4; i++) begin
      fq[i].delete();
      for (int k = 0; k < n; k++) fq[i].push_back(8'(10*i + k));
    end
  endtask

  task automatic set_nom();
    logic [3:0] seq [7];
    seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    for (int c = 0; c < 16; c++) begin
      ren_tab[c]  = 4'b0000;
      mask_tab[c] = 4'b0000;
    end
    for (int c = 1; c <= 7; c++) ren_tab[c] = seq[c-1];
  endtask

  task automatic set_stall();
    logic [3:0] seq [10];
    seq = '{4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0000,
            4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    for (int c = 0; c < 16; c++) begin
      ren_tab[c]  = 4'b0000;
      mask_tab[c] = 4'b0000;
    end
    for (int c = 1; c <= 10; c++) ren_tab[c] = seq[c-1];
    for (int c = 3; c <= 5; c++) mask_tab[c] = 4'b0100;
  endtask

  // Cycle 0 of a tile: start sampled at the end of this cycle.
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    emask = mask_tab[0];
  endtask

  task automatic tile(input int done_c, input int exp_st, input int probe_c,
                      input int pulse_c, input bit hold);
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      start = (c == pulse_c) || (hold && c >= done_c - 1);
      emask = mask_tab[c];
      #1;
      chk($sformatf("r_en_c%0d", c), fifo_r_en, ren_tab[c]);
      chk($sformatf("a_valid_c%0d", c), a_valid, (c >= 2) ? ren_tab[c-2] : 4'b0000);
      chk($sformatf("busy_c%0d", c), busy, 1);
      chk($sformatf("done_c%0d", c), done, 32'(c == done_c));
      if (c == probe_c) chk("row2_k1_value", aout[2], 21);
    end
    chk("stall_cnt", stall_cnt, exp_st);
    for (int i = 0; i < 4; i++) chk("sb_drained", expq[i].size(), 0);
  endtask

  task automatic gap(input bit hold);
    @(negedge clk);
    start = hold;
    emask = 4'b0000;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_r_en", fifo_r_en, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_b = 1'b0; emask = 4'b0000;
    set_nom();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_r_en", fifo_r_en, 0);
    chk("rst_a_out", aout, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_a_valid", av_b, 0);
    reset = 1'b0;

    // Nominal skew.
    load(4); set_nom();
    kick(); tile(10, 0, 6, 0, 1'b0); gap(1'b0);

    // Row 2 forced empty while active: three-cycle stall.
    load(4); set_stall();
    kick(); tile(13, 3, 0, 0, 1'b0); gap(1'b0);

    // Row 3 empty only before its window opens: no stall.
    load(4); set_nom();
    for (int c = 1; c <= 3; c++) mask_tab[c] = 4'b1000;
    kick(); tile(10, 0, 6, 0, 1'b0); gap(1'b0);

    // Reset mid-RUN, then a fresh tile on what is left in the FIFOs.
    load(8); set_nom();
    kick();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk($sformatf("pre_rst_r_en_c%0d", c), fifo_r_en, ren_tab[c]);
      if (c == 4) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_r_en", fifo_r_en, 0);
    chk("post_rst_a_out", aout, 0);
    chk("post_rst_a_valid", a_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_stall_cnt", stall_cnt, 0);
    for (int i = 0; i < 4; i++) expq[i].delete();
    kick(); tile(10, 0, 0, 0, 1'b0); gap(1'b0);

    // Mid-RUN start pulse ignored; held start relaunches after one idle cycle.
    load(8); set_nom();
    kick(); tile(10, 0, 6, 3, 1'b1);
    gap(1'b1);
    tile(10, 0, 0, 0, 1'b0);
    gap(1'b0);

    // Degenerate 1x1 instance.
    fq_b.delete();
    fq_b.push_back(8'hA5);
    @(negedge clk);
    @(negedge clk);
    start_b = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      #1;
      chk($sformatf("b_r_en_c%0d", c), ren_b, 32'(c == 1));
      chk($sformatf("b_a_valid_c%0d", c), av_b, 32'(c == 3));
      chk($sformatf("b_a_out_c%0d", c), ao_b, (c == 3) ? 32'hA5 : 32'h0);
      chk($sformatf("b_done_c%0d", c), done_b, 32'(c == 4));
      chk($sformatf("b_busy_c%0d", c), busy_b, 32'(c <= 4));
    end
    chk("b_stall_cnt", sc_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
